// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ byte producers.
// Latches the winner's byte, strobes the transmitter, tracks data_sent to completion, and acks.
module uart_tx_arbiter #(
  parameter int BITS    = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic [BITS-1:0]         uart_data,
  output logic                    uart_data_ready,
  input  logic                    uart_data_sent,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int PW   = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_gnt_idx;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [BITS-1:0]    r_data;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_timeout_err;

  logic               w_found;
  logic [PW-1:0]      w_win_idx;
  logic [BITS-1:0]    w_win_data;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [PW-1:0]      w_ptr_adv;
  logic               w_wd_expire;

  // Rotating priority scan: first asserted request at ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    int k;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    k         = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && req[k]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(k);
      end
    end
  end

  assign w_win_data   = req_data[int'(w_win_idx)*BITS +: BITS];
  assign w_win_onehot = NUM_REQ'(1) << w_win_idx;
  assign w_ptr_adv    = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + PW'(1);
  assign w_wd_expire  = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_LOAD;
      S_LOAD:  w_next = S_BUSY;
      S_BUSY: begin
        if (uart_data_sent)   w_next = S_DRAIN;
        else if (w_wd_expire) w_next = S_IDLE;
      end
      S_DRAIN: if (!uart_data_sent) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_data    <= '0;
      r_wd_cnt  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_data    <= w_win_data;
            r_grant   <= w_win_onehot;
            r_gnt_idx <= w_win_idx;
          end
        end
        S_LOAD: r_wd_cnt <= '0;
        S_BUSY: begin
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
          if (uart_data_sent) begin
            r_ack <= r_grant;
            r_ptr <= w_ptr_adv;
          end else if (w_wd_expire) begin
            r_ptr   <= w_ptr_adv;
            r_grant <= '0;
          end
        end
        S_DRAIN: if (!uart_data_sent) r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

  // A fresh timeout outranks a simultaneous clear so no abort goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (r_state == S_BUSY && !uart_data_sent && w_wd_expire) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign ack             = r_ack;
  assign grant           = r_grant;
  assign busy            = (r_state != S_IDLE);
  assign uart_data       = r_data;
  assign uart_data_ready = (r_state == S_LOAD);
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays the UART transmitter by hand
// and checks grant/load/ack sequencing, rotation, watchdog and async reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  uart_data;
  logic        uart_data_ready;
  logic        uart_data_sent = 1'b0;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int checks  = 0;
  int errors  = 0;
  int inv_err = 0;

  uart_tx_arbiter #(.BITS(8), .NUM_REQ(4), .TIMEOUT(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .grant           (grant),
    .busy            (busy),
    .uart_data       (uart_data),
    .uart_data_ready (uart_data_ready),
    .uart_data_sent  (uart_data_sent),
    .timeout_err     (timeout_err),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  // Protocol invariants watched on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_data_ready && uart_data_sent) inv_err++;
      if (!$onehot0(grant)) inv_err++;
      if ((ack & ~grant) != 4'b0) inv_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic do_reset();
    rst            = 1'b1;
    req            = '0;
    uart_data_sent = 1'b0;
    err_clr        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the load strobe; returns cycles waited beyond the first.
  task automatic wait_load(input logic [7:0] exp_data, input logic [3:0] exp_gnt,
                           input string tag, output int lat);
    lat = 0;
    @(negedge clk);
    while (!uart_data_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (uart_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_load: uart_data_ready got %b expected 1 within 20 cycles", tag, uart_data_ready);
    end
    checks++;
    if (uart_data !== exp_data) begin
      errors++;
      $display("FAIL %s_data: uart_data got %h expected %h", tag, uart_data, exp_data);
    end
    checks++;
    if (grant !== exp_gnt) begin
      errors++;
      $display("FAIL %s_grant: grant got %b expected %b", tag, grant, exp_gnt);
    end
    @(negedge clk);
    checks++;
    if (uart_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_width: uart_data_ready got %b expected 0", tag, uart_data_ready);
    end
  endtask

  // Transmitter finishes: data_sent rises, ack must pulse once, then data_sent falls.
  task automatic finish_frame(input logic [3:0] exp_gnt, input logic [3:0] rel, input string tag);
    repeat (2) @(negedge clk);
    uart_data_sent = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== exp_gnt) begin
      errors++;
      $display("FAIL %s_ack: ack got %b expected %b", tag, ack, exp_gnt);
    end
    req = req & ~rel;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || grant !== exp_gnt) begin
      errors++;
      $display("FAIL %s_drain: ack/grant got %b/%b expected 0000/%b", tag, ack, grant, exp_gnt);
    end
    uart_data_sent = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: grant/busy got %b/%b expected 0000/0", tag, grant, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack, grant, busy, uart_data, uart_data_ready, timeout_err} !== 19'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {ack, grant, busy, uart_data, uart_data_ready, timeout_err});
    end
    do_reset();
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    req_data = 32'h00A5_0000;
    req      = 4'b0100;
    wait_load(8'hA5, 4'b0100, "single", lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL single_latency: extra cycles got %0d expected 0", lat);
    end
    finish_frame(4'b0100, 4'b0100, "single");
    // Pointer is now 3: index 3 outranks index 0, then the pointer wraps to 0.
    req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
    req      = 4'b1001;
    wait_load(8'hD3, 4'b1000, "ptr3_first", lat);
    finish_frame(4'b1000, 4'b1000, "ptr3_first");
    wait_load(8'hD0, 4'b0001, "ptr_wrap", lat);
    finish_frame(4'b0001, 4'b0001, "ptr_wrap");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bytes [4];
    logic [3:0] exp_gnt;
    int lat;
    exp_bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      wait_load(exp_bytes[k % 4], exp_gnt, $sformatf("rr%0d", k), lat);
      checks++;
      if (lat !== 0) begin
        errors++;
        $display("FAIL rr%0d_latency: extra cycles got %0d expected 0", k, lat);
      end
      finish_frame(exp_gnt, (k == 4) ? 4'b1111 : 4'b0000, $sformatf("rr%0d", k));
    end
  endtask

  task automatic test_rotation();
    int lat;
    do_reset();
    req_data = {8'h00, 8'h00, 8'hB1, 8'h00};
    req      = 4'b0010;
    wait_load(8'hB1, 4'b0010, "rot_setup", lat);
    finish_frame(4'b0010, 4'b0010, "rot_setup");
    req_data = {8'hB3, 8'h00, 8'hC1, 8'h00};
    req      = 4'b1010;
    wait_load(8'hB3, 4'b1000, "rot_idx3", lat);
    finish_frame(4'b1000, 4'b1000, "rot_idx3");
    wait_load(8'hC1, 4'b0010, "rot_idx1", lat);
    finish_frame(4'b0010, 4'b0010, "rot_idx1");
  endtask

  // Holds data_sent low; the watchdog must fire on the 64th BUSY edge.
  task automatic run_timeout(input logic [7:0] exp_data, input logic [3:0] exp_gnt, input string tag);
    logic [3:0] ack_seen;
    int lat;
    ack_seen = '0;
    wait_load(exp_data, exp_gnt, tag, lat);
    repeat (63) begin
      @(negedge clk);
      ack_seen |= ack;
    end
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_early: timeout_err/busy got %b/%b expected 0/1", tag, timeout_err, busy);
    end
    @(negedge clk);
    ack_seen |= ack;
    checks++;
    if (timeout_err !== 1'b1 || grant !== 4'b0 || busy !== 1'b0 || ack_seen !== 4'b0) begin
      errors++;
      $display("FAIL %s_fire: err/grant/busy/ack got %b/%b/%b/%b expected 1/0000/0/0000",
               tag, timeout_err, grant, busy, ack_seen);
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_data = 32'h0000_005A;
    req      = 4'b0001;
    run_timeout(8'h5A, 4'b0001, "wd");
    err_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: timeout_err got %b expected 0", timeout_err);
    end
    // Pointer advanced past index 0; err_clr held through the next timeout, set must win.
    req_data = 32'h0000_6E5B;
    req      = 4'b0011;
    run_timeout(8'h6E, 4'b0010, "wd_set_wins");
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear2: timeout_err got %b expected 0", timeout_err);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat;
    do_reset();
    req_data = {8'h00, 8'h00, 8'h91, 8'h00};
    req      = 4'b0010;
    wait_load(8'h91, 4'b0010, "ar_setup", lat);
    finish_frame(4'b0010, 4'b0010, "ar_setup");
    req_data = {8'h00, 8'h92, 8'h00, 8'h90};
    req      = 4'b0100;
    wait_load(8'h92, 4'b0100, "ar_frame", lat);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, grant, busy, uart_data, uart_data_ready, timeout_err} !== 19'b0) begin
      errors++;
      $display("FAIL async_reset: outputs got %h expected 0 before next edge",
               {ack, grant, busy, uart_data, uart_data_ready, timeout_err});
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0101;
    wait_load(8'h90, 4'b0001, "ar_ptr0", lat);
    finish_frame(4'b0001, 4'b0001, "ar_ptr0");
    wait_load(8'h92, 4'b0100, "ar_next", lat);
    finish_frame(4'b0100, 4'b0100, "ar_next");
  endtask

  task automatic test_dropped_req();
    logic [3:0] seen;
    int lat;
    do_reset();
    req_data = {8'h00, 8'h00, 8'h77, 8'h66};
    req      = 4'b0001;
    wait_load(8'h66, 4'b0001, "drop", lat);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    finish_frame(4'b0001, 4'b0001, "drop");
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen |= grant | ack;
    end
    checks++;
    if (seen !== 4'b0) begin
      errors++;
      $display("FAIL drop_unserved: grant|ack got %b expected 0000", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_timeout();
    test_async_reset();
    test_dropped_req();
    checks++;
    if (inv_err !== 0) begin
      errors++;
      $display("FAIL invariants: violations got %0d expected 0", inv_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
